// File: rtl/seq_generator.sv
`default_nettype none
// ============================================================================
//  Module   : seq_generator
//  Purpose  : Serial pattern generator. On an accepted start the PAT_W-bit
//             pattern is captured and emitted MSB first, repeated 'reps'
//             times back to back. An optional even-parity bit (XOR of the
//             captured pattern) follows each repetition. A one-cycle done
//             pulse closes every transmission, including reps = 0.
//
//  Options  : SEQ_GEN_PARITY_EN - when defined, enables the PAR state and
//             appends one parity bit after every repetition. When undefined,
//             PAR is unreachable and each repetition is exactly PAT_W bits.
//
//  Parameters
//    PAT_W    pattern width in bits, 2..16 (default 8)
//
//  Ports
//    clk      in   1      rising-edge clock
//    rst      in   1      asynchronous reset, active low (0 = reset)
//    start    in   1      request to begin a transmission (ignored while busy)
//    pattern  in   PAT_W  bit sequence to emit, MSB first
//    reps     in   4      number of back-to-back repetitions, 0..15
//    out      out  1      serial bit stream (0 whenever valid = 0)
//    valid    out  1      out carries a sequence bit this cycle
//    busy     out  1      transmission in progress
//    done     out  1      one-cycle completion pulse
//
//  Revision : 1.0  initial release
// ============================================================================

module seq_generator #(
   parameter int PAT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [3:0]       reps,
   output logic             out,
   output logic             valid,
   output logic             busy,
   output logic             done
);

   // Bit counter must hold the value PAT_W itself (up to 16).
   localparam int CNT_W = $clog2(PAT_W + 1);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PAT_W);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_PAR   = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]       state_q,  state_d;
   logic [PAT_W-1:0] shreg_q,  shreg_d;   // working shift register, MSB = current bit
   logic [PAT_W-1:0] pat_q,    pat_d;     // captured pattern, reloaded each repetition
   logic [CNT_W-1:0] bitcnt_q, bitcnt_d;  // bits still to emit in this repetition
   logic [3:0]       repcnt_q, repcnt_d;  // repetitions still to complete

   logic             end_rep;             // current cycle closes a repetition

   // -------------------------------------------------------------------------
   // State and datapath registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         shreg_q  <= '0;
         pat_q    <= '0;
         bitcnt_q <= '0;
         repcnt_q <= '0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         pat_q    <= pat_d;
         bitcnt_q <= bitcnt_d;
         repcnt_q <= repcnt_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and datapath logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      pat_d    = pat_q;
      bitcnt_d = bitcnt_q;
      repcnt_d = repcnt_q;
      end_rep  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // pattern and reps are sampled only here; start is only seen here,
            // so a start while busy can never touch the captured values.
            if (start) begin
               pat_d    = pattern;
               shreg_d  = pattern;
               bitcnt_d = CNT_FULL;
               repcnt_d = reps;
               state_d  = (reps == 4'd0) ? ST_DONE : ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            shreg_d  = shreg_q << 1;
            bitcnt_d = bitcnt_q - CNT_ONE;
            if (bitcnt_q == CNT_ONE) begin
`ifdef SEQ_GEN_PARITY_EN
               state_d = ST_PAR;
`else
               end_rep = 1'b1;
`endif
            end
         end

`ifdef SEQ_GEN_PARITY_EN
         ST_PAR: begin
            end_rep = 1'b1;
         end
`endif

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Closing a repetition: either reload the captured pattern with no idle
      // gap, or finish. repcnt_q is never 0 here because reps = 0 skips
      // straight to DONE, so "more to go" is simply repcnt_q > 1.
      if (end_rep) begin
         repcnt_d = repcnt_q - 4'd1;
         if (repcnt_q != 4'd1) begin
            shreg_d  = pat_q;
            bitcnt_d = CNT_FULL;
            state_d  = ST_SHIFT;
         end else begin
            state_d  = ST_DONE;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Outputs: decoded from registered state only, so reset forces them low
   // without waiting for a clock edge.
   // -------------------------------------------------------------------------
   always_comb begin
      out   = 1'b0;
      valid = 1'b0;
      busy  = (state_q != ST_IDLE);
      done  = (state_q == ST_DONE);

      case (state_q)
         ST_SHIFT: begin
            valid = 1'b1;
            out   = shreg_q[PAT_W-1];
         end
         ST_PAR: begin
            valid = 1'b1;
`ifdef SEQ_GEN_PARITY_EN
            out   = ^pat_q;  // even parity over the captured pattern
`else
            out   = 1'b0;
`endif
         end
         default: begin
            out   = 1'b0;
            valid = 1'b0;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_seq_generator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_generator
//  Purpose  : Self-checking bench for seq_generator (PAT_W = 8). A table of
//             {inputs, expected outputs} records drives single-cycle checks;
//             hand-written sequences cover repetitions, parity and reset.
//  Revision : 1.0  initial release
// ============================================================================

module tb_seq_generator;

   typedef struct {
      logic       start;
      logic [7:0] pattern;
      logic [3:0] reps;
      logic [3:0] exp;      // {out, valid, busy, done} after the edge
      string      name;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [7:0] pattern = 8'h00;
   logic [3:0] reps = 4'd0;
   logic       out, valid, busy, done;

   int n_cmp = 0;
   int n_err = 0;

   vec_t tbl[$];

   seq_generator #(.PAT_W(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .pattern (pattern),
      .reps    (reps),
      .out     (out),
      .valid   (valid),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [3:0] exp);
      n_cmp++;
      if ({out, valid, busy, done} !== exp) begin
         n_err++;
         $display("FAIL %s: got out/valid/busy/done=%b required %b",
                  name, {out, valid, busy, done}, exp);
      end
   endtask

   task automatic add(input logic s, input logic [7:0] p, input logic [3:0] r,
                      input logic [3:0] e, input string n);
      vec_t v;
      v.start = s; v.pattern = p; v.reps = r; v.exp = e; v.name = n;
      tbl.push_back(v);
   endtask

   // Drive inputs, take one rising edge, check 1 ns later, return at negedge.
   task automatic step(input logic s, input logic [7:0] p, input logic [3:0] r,
                       input logic [3:0] e, input string n);
      start = s; pattern = p; reps = r;
      @(posedge clk);
      #1;
      chk(n, e);
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] p;
      int         busy_cnt;

      // Reset state, no clock edge yet needed
      #2;
      chk("reset_state", 4'b0000);
      @(negedge clk);
      rst = 1'b1;

`ifndef SEQ_GEN_PARITY_EN
      // ---- Basic: B2, reps=1; pattern/reps change after acceptance ----
      p = 8'b1011_0010;
      add(1'b1, p, 4'd1, {p[7], 3'b110}, "basic_b0");
      for (int k = 1; k < 8; k++)
         add(1'b0, 8'hFF, 4'd15, {p[7-k], 3'b110}, $sformatf("basic_b%0d", k));
      add(1'b0, 8'h00, 4'd0, 4'b0011, "basic_done");
      add(1'b0, 8'h00, 4'd0, 4'b0000, "basic_idle");

      // ---- Zero reps: no valid, done one cycle after acceptance ----
      add(1'b1, 8'hFF, 4'd0, 4'b0011, "zero_done");
      add(1'b0, 8'hFF, 4'd0, 4'b0000, "zero_idle");

      // ---- Start while busy is ignored ----
      p = 8'hA5;
      add(1'b1, p, 4'd1, {p[7], 3'b110}, "ign_b0");
      for (int k = 1; k < 8; k++)
         add((k == 3), 8'h00, 4'd5, {p[7-k], 3'b110}, $sformatf("ign_b%0d", k));
      add(1'b0, 8'h00, 4'd0, 4'b0011, "ign_done");
      add(1'b0, 8'h00, 4'd0, 4'b0000, "ign_idle");

      // ---- Start held high: restart on first edge after returning to IDLE ----
      p = 8'hC3;
      for (int k = 0; k < 8; k++)
         add(1'b1, p, 4'd1, {p[7-k], 3'b110}, $sformatf("hold1_b%0d", k));
      add(1'b1, p, 4'd1, 4'b0011, "hold1_done");
      add(1'b1, p, 4'd1, 4'b0000, "hold_idle");
      for (int k = 0; k < 8; k++)
         add((k == 0), p, 4'd1, {p[7-k], 3'b110}, $sformatf("hold2_b%0d", k));
      add(1'b0, p, 4'd1, 4'b0011, "hold2_done");
      add(1'b0, p, 4'd1, 4'b0000, "hold2_idle");

      foreach (tbl[i])
         step(tbl[i].start, tbl[i].pattern, tbl[i].reps, tbl[i].exp, tbl[i].name);

      // ---- Repetitions: F0 x3, 24 contiguous bits, 25 busy cycles ----
      busy_cnt = 0;
      start = 1'b1; pattern = 8'hF0; reps = 4'd3;
      for (int k = 0; k < 26; k++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         if (busy) busy_cnt++;
         if (k < 24)
            chk($sformatf("rep_b%0d", k), {((k % 8) < 4), 3'b110});
         else if (k == 24)
            chk("rep_done", 4'b0011);
         else
            chk("rep_idle", 4'b0000);
      end
      n_cmp++;
      if (busy_cnt != 25) begin
         n_err++;
         $display("FAIL rep_busy_cycles: got %0d required 25", busy_cnt);
      end
      @(negedge clk);

      // ---- Reset mid-operation at bit 4 of reps=2 ----
      p = 8'b1011_0010;
      start = 1'b1; pattern = p; reps = 4'd2;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         chk($sformatf("rst_pre_b%0d", k), {p[7-k], 3'b110});
      end
      #2;
      rst = 1'b0;
      #1;
      chk("rst_async", 4'b0000);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("rst_hold%0d", k), 4'b0000);
      end
      @(negedge clk);
      rst = 1'b1;
      p = 8'h6B;
      step(1'b1, p, 4'd1, {p[7], 3'b110}, "restart_b0");
      for (int k = 1; k < 8; k++)
         step(1'b0, p, 4'd1, {p[7-k], 3'b110}, $sformatf("restart_b%0d", k));
      step(1'b0, p, 4'd1, 4'b0011, "restart_done");
      step(1'b0, p, 4'd1, 4'b0000, "restart_idle");
`else
      // ---- Parity: B2 x2, 9 bits per repetition, parity 0 ----
      p = 8'b1011_0010;
      step(1'b1, p, 4'd2, {p[7], 3'b110}, "par_r0_b0");
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 9; k++) begin
            if (r == 0 && k == 0) continue;
            if (k < 8)
               step(1'b0, 8'h00, 4'd0, {p[7-k], 3'b110}, $sformatf("par_r%0d_b%0d", r, k));
            else
               step(1'b0, 8'h00, 4'd0, 4'b0110, $sformatf("par_r%0d_par", r));
         end
      end
      step(1'b0, 8'h00, 4'd0, 4'b0011, "par_done");
      step(1'b0, 8'h00, 4'd0, 4'b0000, "par_idle");

      // ---- Parity: 80, parity bit 1 ----
      p = 8'b1000_0000;
      step(1'b1, p, 4'd1, {p[7], 3'b110}, "par80_b0");
      for (int k = 1; k < 8; k++)
         step(1'b0, p, 4'd1, {p[7-k], 3'b110}, $sformatf("par80_b%0d", k));
      step(1'b0, p, 4'd1, 4'b1110, "par80_par");
      step(1'b0, p, 4'd1, 4'b0011, "par80_done");
      step(1'b0, p, 4'd1, 4'b0000, "par80_idle");

      // ---- Zero reps with parity enabled ----
      step(1'b1, 8'hFF, 4'd0, 4'b0011, "par_zero_done");
      step(1'b0, 8'hFF, 4'd0, 4'b0000, "par_zero_idle");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
